// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter
//
// Parallel-to-serial shifter for the bit-serial sequence detectors. A WIDTH-bit
// word is taken over a valid/ready handshake and sent out on x one bit per
// clock. bit_valid marks the word bits and last marks the final bit of each
// word. While no word is in flight, x is held at 0, so a downstream detector
// sees only zeros.
//
// Optional feature macro: SER_SKID_EN
//   When defined, a one-word holding register lets the next word be accepted
//   while the current one is still shifting. Words then follow back to back
//   with no idle cycle between them.
//
// Parameters
//   WIDTH      word width in bits, 2..32
//   LSB_FIRST  0 = MSB transmitted first, 1 = LSB transmitted first
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        parallel word, sampled only at an accepting edge
//   din_valid  din carries a word this cycle
//   din_ready  shifter can take a word this cycle (no path from din_valid)
//   x          serial data, 0 whenever bit_valid is low
//   bit_valid  x carries a word bit this cycle
//   last       x carries the final bit of the word
//   busy       shifter is in the SHIFT state
module serial_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shifted;
  logic             accept;

`ifdef SER_SKID_EN
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;

  // Ready depends only on the hold slot, so a word can be taken while shifting.
  assign din_ready = !hold_full;
`else
  assign din_ready = (state == IDLE);
`endif

  assign accept = din_valid && din_ready;

  // Move the shift register one place toward the output end. Vacated bits fill
  // with 0, so the register is empty once a whole word has been sent.
  always_comb begin
    if (LSB_FIRST != 0) shifted = shreg >> 1;
    else                shifted = shreg << 1;
  end

  // All outputs are decoded from registers only. An asynchronous reset drops
  // x and the strobes in the same instant that the state is cleared.
  assign busy      = (state == SHIFT);
  assign bit_valid = (state == SHIFT);
  assign last      = (state == SHIFT) && (cnt == '0);
  assign x         = (state == SHIFT) &&
                     ((LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1]);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef SER_SKID_EN
  // Holding register for the word waiting behind the one being shifted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end
`endif

  // Next-state logic. A word is loaded from IDLE. In SHIFT the register shifts
  // once per edge. At the final bit, the shifter either returns to IDLE or
  // (with the skid buffer) goes straight on to the next word.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef SER_SKID_EN
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt = din;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nxt = shifted;
        cnt_nxt   = cnt - 1'b1;
        if (cnt == '0) begin
`ifdef SER_SKID_EN
          if (hold_full) begin
            // The held word moves into the shifter. A word arriving on this
            // same edge takes its place in the hold slot.
            shreg_nxt     = hold;
            cnt_nxt       = CNT_LOAD;
            hold_full_nxt = accept;
            if (accept) hold_nxt = din;
          end else if (accept) begin
            // The hold slot is empty. A word offered on the final edge goes
            // directly into the shifter so that it is neither stranded nor
            // delayed.
            shreg_nxt = din;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
`else
          state_nxt = IDLE;
          cnt_nxt   = '0;
`endif
        end else begin
`ifdef SER_SKID_EN
          if (accept) begin
            hold_nxt      = din;
            hold_full_nxt = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb_serial_tx_shifter
//
// Drives two shifter instances from the same stimulus. One is MSB-first and
// the other is LSB-first, both 8 bits wide. The expected serial streams are
// written by hand in the vector table. At every accepted word, the stream for
// that word is pushed onto a per-lane queue. The queue is popped each time the
// lane shows bit_valid.
module tb_serial_tx_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;

  logic din_ready_m, x_m, bit_valid_m, last_m, busy_m;
  logic din_ready_l, x_l, bit_valid_l, last_l, busy_l;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic x;
    logic last;
  } exp_bit_t;

  exp_bit_t q_msb[$];
  exp_bit_t q_lsb[$];

  // Streams are written first-transmitted bit leftmost.
  logic [7:0] exp_msb;
  logic [7:0] exp_lsb;

  int idle_run   = 0;
  bit after_last = 1'b0;
  int last_gap   = -1;

  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_stream;
    logic [7:0] lsb_stream;
    int         idle_after;
  } vec_t;

  vec_t vectors[6];

  serial_tx_shifter #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_m), .x(x_m), .bit_valid(bit_valid_m),
    .last(last_m), .busy(busy_m)
  );

  serial_tx_shifter #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .x(x_l), .bit_valid(bit_valid_l),
    .last(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present a word and hold it until both lanes are ready. Returns at the
  // negedge after the accepting edge with din_valid still high.
  task automatic applyStimulus(input logic [7:0] word, input logic [7:0] msb_stream,
                               input logic [7:0] lsb_stream, output int waited);
    waited    = 0;
    din       = word;
    exp_msb   = msb_stream;
    exp_lsb   = lsb_stream;
    din_valid = 1'b1;
    while (!(din_ready_m && din_ready_l) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checkOutput("accept_timeout", {30'd0, din_ready_m, din_ready_l}, 32'd3);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic holdIdle(input int n);
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard push: a word is taken at any edge with valid and ready.
  always @(posedge clk) begin
    if (rst && din_valid && din_ready_m)
      for (int i = 0; i < 8; i++) q_msb.push_back('{x: exp_msb[7-i], last: (i == 7)});
    if (rst && din_valid && din_ready_l)
      for (int i = 0; i < 8; i++) q_lsb.push_back('{x: exp_lsb[7-i], last: (i == 7)});
  end

  // Scoreboard pop and idle checks, sampled away from the active edge. The gap
  // between consecutive words is also tracked on the MSB lane.
  always @(negedge clk) begin
    exp_bit_t e;
    if (bit_valid_m) begin
      if (q_msb.size() == 0) begin
        checkOutput("msb_spurious_bit_valid", {31'd0, bit_valid_m}, 32'd0);
      end else begin
        e = q_msb.pop_front();
        checkOutput("msb_x", {31'd0, x_m}, {31'd0, e.x});
        checkOutput("msb_last", {31'd0, last_m}, {31'd0, e.last});
        checkOutput("msb_busy", {31'd0, busy_m}, 32'd1);
      end
      if (after_last) begin
        last_gap   = idle_run;
        after_last = 1'b0;
      end
      idle_run = 0;
      if (last_m) after_last = 1'b1;
    end else begin
      checkOutput("msb_idle_outputs", {29'd0, x_m, last_m, busy_m}, 32'd0);
      idle_run++;
    end

    if (bit_valid_l) begin
      if (q_lsb.size() == 0) begin
        checkOutput("lsb_spurious_bit_valid", {31'd0, bit_valid_l}, 32'd0);
      end else begin
        e = q_lsb.pop_front();
        checkOutput("lsb_x", {31'd0, x_l}, {31'd0, e.x});
        checkOutput("lsb_last", {31'd0, last_l}, {31'd0, e.last});
      end
    end else begin
      checkOutput("lsb_idle_outputs", {29'd0, x_l, last_l, busy_l}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;

    vectors[0] = '{din: 8'h01, msb_stream: 8'h01, lsb_stream: 8'h80, idle_after: 0};
    vectors[1] = '{din: 8'h80, msb_stream: 8'h80, lsb_stream: 8'h01, idle_after: 1};
    vectors[2] = '{din: 8'h12, msb_stream: 8'h12, lsb_stream: 8'h48, idle_after: 3};
    vectors[3] = '{din: 8'hF0, msb_stream: 8'hF0, lsb_stream: 8'h0F, idle_after: 0};
    vectors[4] = '{din: 8'h3C, msb_stream: 8'h3C, lsb_stream: 8'h3C, idle_after: 2};
    vectors[5] = '{din: 8'h6B, msb_stream: 8'h6B, lsb_stream: 8'hD6, idle_after: 0};

    // Hold reset for two cycles with a word offered. Nothing may be taken.
    rst       = 1'b1;
    din       = 8'hA5;
    din_valid = 1'b1;
    exp_msb   = 8'hA5;
    exp_lsb   = 8'hA5;
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_din_ready", {30'd0, din_ready_m, din_ready_l}, 32'd3);
    end

    // Release reset. The word is taken at the very first edge.
    rst = 1'b1;
    applyStimulus(8'hA5, 8'hA5, 8'hA5, waited);
    checkOutput("accept_first_edge_wait", waited, 0);
    holdIdle(10);

    // Table-driven words with varied idle gaps. A gap of 0 leaves the next
    // word waiting on din_ready.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].din, vectors[i].msb_stream, vectors[i].lsb_stream, waited);
      if (vectors[i].idle_after > 0) holdIdle(vectors[i].idle_after);
    end
    holdIdle(12);

    // Back-to-back words with din_valid held high.
    last_gap = -1;
    applyStimulus(8'hFF, 8'hFF, 8'hFF, waited);
    applyStimulus(8'h00, 8'h00, 8'h00, waited);
    holdIdle(20);
`ifdef SER_SKID_EN
    checkOutput("b2b_gap_cycles", last_gap, 0);
`else
    checkOutput("b2b_gap_cycles", last_gap, 1);
`endif

`ifndef SER_SKID_EN
    // Backpressure: a word offered mid-shift is refused until IDLE.
    applyStimulus(8'h3C, 8'h3C, 8'h3C, waited);
    din       = 8'h12;
    exp_msb   = 8'h12;
    exp_lsb   = 8'h48;
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("backpressure_din_ready", {30'd0, din_ready_m, din_ready_l}, 32'd0);
    end
    applyStimulus(8'h12, 8'h12, 8'h48, waited);
    holdIdle(12);
`endif

    // Reset in the middle of a word: the outputs drop at once and the rest of
    // the word is discarded.
    applyStimulus(8'hA5, 8'hA5, 8'hA5, waited);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q_msb.delete();
    q_lsb.delete();
    #1;
    checkOutput("async_reset_outputs",
                {28'd0, x_m, x_l, bit_valid_m, bit_valid_l}, 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    holdIdle(2);
    applyStimulus(8'hF0, 8'hF0, 8'h0F, waited);
    holdIdle(12);

    checkOutput("msb_queue_drained", q_msb.size(), 0);
    checkOutput("lsb_queue_drained", q_lsb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
